// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: state encoding,
// command/response framing and the status-byte layout.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        WAIT_ALU,
        RSP
    } seq_state_e;

    localparam int CMD_BYTES = 5;
    localparam int RSP_BYTES = 3;

    localparam int STAT_OVF = 7;
    localparam int STAT_TMO = 6;

    localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

    function automatic logic [7:0] status_byte(input logic ovf, input logic tmo);
        logic [7:0] s;
        s           = '0;
        s[STAT_OVF] = ovf;
        s[STAT_TMO] = tmo;
        return s;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings: command FIFO reader,
// ALU request/result and response FIFO writer.
interface alu_cmd_sequencer_if;

    logic        cmd_rd_en;
    logic [7:0]  cmd_data;
    logic        cmd_empty;

    logic [15:0] alu_operand_a;
    logic [15:0] alu_operand_b;
    logic [2:0]  alu_op;
    logic        alu_valid_in;
    logic [15:0] alu_result;
    logic        alu_valid_out;
    logic        alu_overflow;

    logic        rsp_wr_en;
    logic [7:0]  rsp_data;
    logic        rsp_full;

    modport master (
        output cmd_rd_en,
        input  cmd_data,
        input  cmd_empty,
        output alu_operand_a,
        output alu_operand_b,
        output alu_op,
        output alu_valid_in,
        input  alu_result,
        input  alu_valid_out,
        input  alu_overflow,
        output rsp_wr_en,
        output rsp_data,
        input  rsp_full
    );

    modport slave (
        input  cmd_rd_en,
        output cmd_data,
        output cmd_empty,
        input  alu_operand_a,
        input  alu_operand_b,
        input  alu_op,
        input  alu_valid_in,
        output alu_result,
        output alu_valid_out,
        output alu_overflow,
        input  rsp_wr_en,
        input  rsp_data,
        output rsp_full
    );

endinterface

// File: rtl/alu_seq_timeout_cnt.sv
// Clearable up-counter that saturates at TIMEOUT_CYCLES-1; tc_o flags the last
// cycle of the allowed wait window.
module alu_seq_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Pops 5-byte commands from a byte FIFO, runs one ALU operation per command and
// pushes a 3-byte status/result response, with a bounded wait on the ALU.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 err_clr,
    alu_cmd_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     cmd_count
);

    localparam logic [2:0] LAST_CMD_IDX = 3'(CMD_BYTES - 1);
    localparam logic [2:0] LAST_RSP_IDX = 3'(RSP_BYTES - 1);

    seq_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       op_q, op_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [15:0]      res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             terr_q, terr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_clr, tmo_en, tmo_tc;

    alu_seq_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .tc_o  (tmo_tc)
    );

    // idx_q walks command bytes in CAPTURE and response bytes in RSP; it is 0 between the two.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        op_d              = op_q;
        a_d               = a_q;
        b_d               = b_q;
        res_d             = res_q;
        ovf_d             = ovf_q;
        tmo_d             = tmo_q;
        terr_d            = terr_q & ~err_clr;
        cnt_d             = cnt_q;
        tmo_clr           = 1'b0;
        tmo_en            = 1'b0;
        bus.cmd_rd_en     = 1'b0;
        bus.alu_valid_in  = 1'b0;
        bus.rsp_wr_en     = 1'b0;
        bus.rsp_data      = '0;

        case (state_q)
            IDLE: begin
                if (enable && !bus.cmd_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!bus.cmd_empty) begin
                    bus.cmd_rd_en = 1'b1;
                    state_d       = CAPTURE;
                end
            end
            CAPTURE: begin
                case (idx_q)
                    3'd0:    op_d       = bus.cmd_data[2:0];
                    3'd1:    a_d[15:8]  = bus.cmd_data;
                    3'd2:    a_d[7:0]   = bus.cmd_data;
                    3'd3:    b_d[15:8]  = bus.cmd_data;
                    default: b_d[7:0]   = bus.cmd_data;
                endcase
                if (idx_q == LAST_CMD_IDX) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                bus.alu_valid_in = 1'b1;
                tmo_clr          = 1'b1;
                state_d          = WAIT_ALU;
            end
            WAIT_ALU: begin
                tmo_en = 1'b1;
                if (bus.alu_valid_out) begin
                    res_d   = bus.alu_result;
                    ovf_d   = bus.alu_overflow;
                    tmo_d   = 1'b0;
                    state_d = RSP;
                end else if (tmo_tc) begin
                    res_d   = TIMEOUT_RESULT;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b1;
                    terr_d  = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                case (idx_q)
                    3'd0:    bus.rsp_data = status_byte(ovf_q, tmo_q);
                    3'd1:    bus.rsp_data = res_q[15:8];
                    default: bus.rsp_data = res_q[7:0];
                endcase
                if (!bus.rsp_full) begin
                    bus.rsp_wr_en = 1'b1;
                    if (idx_q == LAST_RSP_IDX) begin
                        idx_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.alu_operand_a = a_q;
    assign bus.alu_operand_b = b_q;
    assign bus.alu_op        = op_q;
    assign busy              = (state_q != IDLE);
    assign timeout_err       = terr_q;
    assign cmd_count         = cnt_q;

endmodule
